// File: rtl/my_pkg.sv
// Shared definitions for the RV32I front end.
//   RV_NOP        : canonical ADDI x0,x0,0 used for IF/ID bubbles
//   fetch_state_t : fetch FSM states (idle / response pending / stale response pending)
//   fetch_entry_t : {pc, inst} pair carried by the skid buffer and IF/ID register
package my_pkg;

    localparam logic [31:0] RV_NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        F_IDLE,
        F_WAIT,
        F_DROP
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/rv_fetch_skid.sv
// One-entry skid buffer for the fetch stage. Parks a memory response that
// arrives while the IF/ID register is stalled.
// Ports:
//   clk, rst_n   : clock, synchronous active-low reset
//   i_wr         : load i_wr_entry and mark full
//   i_wr_entry   : {pc, inst} to park
//   i_drain      : entry consumed by IF/ID, clear full
//   i_clr        : flush (redirect), clear full
//   o_full       : entry valid
//   o_entry      : parked {pc, inst}
module rv_fetch_skid
    import my_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_wr,
    input  fetch_entry_t i_wr_entry,
    input  logic         i_drain,
    input  logic         i_clr,
    output logic         o_full,
    output fetch_entry_t o_entry
);

    logic         r_full;
    fetch_entry_t r_entry;

    // Flush beats write; a write in the same cycle as a drain refills the
    // entry, so write beats drain.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_full  <= 1'b0;
            r_entry <= '0;
        end else if (i_clr) begin
            r_full  <= 1'b0;
        end else if (i_wr) begin
            r_full  <= 1'b1;
            r_entry <= i_wr_entry;
        end else if (i_drain) begin
            r_full  <= 1'b0;
        end
    end

    assign o_full  = r_full;
    assign o_entry = r_entry;

endmodule

// File: rtl/rv_fetch_stage.sv
// Instruction-fetch stage of the 5-stage RV32I pipeline: owns the PC, the
// single-outstanding imem request tracker, a 1-entry skid buffer and the
// IF/ID pipeline register.
// Ports:
//   clk, rst_n                      : clock, synchronous active-low reset
//   stall_fetch                     : block presenting a new imem request
//   stall_decode                    : hold the IF/ID register
//   redirect_valid, redirect_pc     : EX redirect / front-end flush
//   imem_req_valid/addr/ready       : request handshake (valid/addr combinational)
//   imem_rsp_valid/data             : in-order response, one per accepted request
//   if_id_valid/pc/inst             : IF/ID register (NOP when invalid)
// Optional build macro RV_FETCH_PERF_EN adds perf_fetch_cnt / perf_bubble_cnt.
module rv_fetch_stage
    import my_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_fetch,
    input  logic        stall_decode,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        if_id_valid,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_inst
`ifdef RV_FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_bubble_cnt
`endif
);

    fetch_state_t r_state, w_state_nxt;
    logic [31:0]  r_pc;
    logic [31:0]  r_req_pc;
    logic         r_req_pend;
    logic         r_if_valid;
    fetch_entry_t r_if_entry;

    logic         w_buf_full;
    fetch_entry_t w_buf_entry;
    fetch_entry_t w_rsp_entry;

    logic         w_rsp_acc;
    logic         w_ifid_upd;
    logic         w_rsp_to_ifid;
    logic         w_rsp_to_buf;
    logic         w_can_issue;
    logic         w_req_valid;
    logic         w_req_fire;

    logic         w_if_load;
    logic         w_if_nxt_vld;
    fetch_entry_t w_if_nxt;
    logic         w_bubble;

    // ---------------- response routing ----------------
    assign w_rsp_acc     = (r_state == F_WAIT) && imem_rsp_valid && !redirect_valid;
    assign w_ifid_upd    = !stall_decode || !r_if_valid;
    assign w_rsp_to_ifid = w_rsp_acc && w_ifid_upd && !w_buf_full;
    assign w_rsp_to_buf  = w_rsp_acc && !w_rsp_to_ifid;
    assign w_rsp_entry   = '{pc: r_req_pc, inst: imem_rsp_data};

    // ---------------- request side ----------------
    // Back-to-back issue from WAIT only when the live response goes straight
    // to IF/ID. If it is being parked, the buffer is about to fill and a
    // second in-flight response would have nowhere to go.
    assign w_can_issue = !stall_fetch && !w_buf_full && !redirect_valid &&
                         ((r_state == F_IDLE) || ((r_state == F_WAIT) && w_rsp_to_ifid));

    // A presented-but-unaccepted request is held until accepted; only a
    // redirect (or reset) withdraws it.
    assign w_req_valid    = rst_n && !redirect_valid && (r_req_pend || w_can_issue);
    assign w_req_fire     = w_req_valid && imem_req_ready;
    assign imem_req_valid = w_req_valid;
    assign imem_req_addr  = r_pc;

    // ---------------- FSM ----------------
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            F_IDLE: begin
                if (w_req_fire) w_state_nxt = F_WAIT;
            end
            F_WAIT: begin
                if (redirect_valid)      w_state_nxt = imem_rsp_valid ? F_IDLE : F_DROP;
                else if (imem_rsp_valid) w_state_nxt = w_req_fire ? F_WAIT : F_IDLE;
            end
            F_DROP: begin
                if (imem_rsp_valid) w_state_nxt = F_IDLE;
            end
            default: w_state_nxt = F_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= F_IDLE;
            r_pc       <= RESET_PC;
            r_req_pc   <= '0;
            r_req_pend <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_req_pend <= w_req_valid && !imem_req_ready;
            if (redirect_valid)  r_pc <= {redirect_pc[31:2], 2'b00};
            else if (w_req_fire) r_pc <= r_pc + 32'd4;
            if (w_req_fire)      r_req_pc <= r_pc;
        end
    end

    // ---------------- skid buffer ----------------
    rv_fetch_skid u_skid (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_wr       (w_rsp_to_buf),
        .i_wr_entry (w_rsp_entry),
        .i_drain    (w_ifid_upd && w_buf_full),
        .i_clr      (redirect_valid),
        .o_full     (w_buf_full),
        .o_entry    (w_buf_entry)
    );

    // ---------------- IF/ID register ----------------
    // Redirect forces a bubble even when decode is stalled.
    always_comb begin
        w_if_load    = 1'b0;
        w_if_nxt_vld = 1'b0;
        w_if_nxt     = '{pc: 32'h0, inst: RV_NOP};
        if (redirect_valid) begin
            w_if_load = 1'b1;
        end else if (w_ifid_upd) begin
            w_if_load = 1'b1;
            if (w_buf_full) begin
                w_if_nxt_vld = 1'b1;
                w_if_nxt     = w_buf_entry;
            end else if (w_rsp_acc) begin
                w_if_nxt_vld = 1'b1;
                w_if_nxt     = w_rsp_entry;
            end
        end
    end

    assign w_bubble = w_if_load && !w_if_nxt_vld;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_if_valid <= 1'b0;
            r_if_entry <= '{pc: 32'h0, inst: RV_NOP};
        end else if (w_if_load) begin
            r_if_valid <= w_if_nxt_vld;
            r_if_entry <= w_if_nxt;
        end
    end

    assign if_id_valid = r_if_valid;
    assign if_id_pc    = r_if_entry.pc;
    assign if_id_inst  = r_if_entry.inst;

`ifdef RV_FETCH_PERF_EN
    logic [31:0] r_perf_fetch;
    logic [31:0] r_perf_bubble;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_perf_fetch  <= '0;
            r_perf_bubble <= '0;
        end else begin
            if (w_rsp_acc) r_perf_fetch  <= r_perf_fetch + 32'd1;
            if (w_bubble)  r_perf_bubble <= r_perf_bubble + 32'd1;
        end
    end

    assign perf_fetch_cnt  = r_perf_fetch;
    assign perf_bubble_cnt = r_perf_bubble;
`endif

endmodule

// File: tb/tb_rv_fetch_stage.sv
// Directed bench for rv_fetch_stage. A small imem model answers each accepted
// request after mem_lat cycles with inst = {16'hC0DE, addr[15:0]}.
// Inputs change on the falling edge; outputs are sampled 2 time units later.
module tb_rv_fetch_stage;
    import my_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall_fetch = 1'b0;
    logic        stall_decode = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready = 1'b1;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = 32'h0;
    logic        if_id_valid;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_inst;
`ifdef RV_FETCH_PERF_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_bubble_cnt;
`endif

    int          checks = 0;
    int          errors = 0;

    // memory model state
    int          mem_lat = 1;
    int          mem_cnt = 0;
    logic [31:0] mem_addr = 32'h0;
    logic        fire_now = 1'b0;
    logic        keep_stale = 1'b0;

    rv_fetch_stage #(.RESET_PC(32'h0000_0100)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall_fetch    (stall_fetch),
        .stall_decode   (stall_decode),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .if_id_valid    (if_id_valid),
        .if_id_pc       (if_id_pc),
        .if_id_inst     (if_id_inst)
`ifdef RV_FETCH_PERF_EN
        ,
        .perf_fetch_cnt  (perf_fetch_cnt),
        .perf_bubble_cnt (perf_bubble_cnt)
`endif
    );

    always #5 clk = ~clk;

    // imem model: single outstanding request, fixed latency
    always @(negedge clk) begin
        if (mem_cnt == 1) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = {16'hC0DE, mem_addr[15:0]};
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 32'h0;
        end
        if (mem_cnt > 0) mem_cnt = mem_cnt - 1;
        if (!rst_n && !keep_stale) begin
            mem_cnt        = 0;
            imem_rsp_valid = 1'b0;
        end
        #1;
        fire_now = imem_req_valid && imem_req_ready;
        if (fire_now) begin
            mem_addr = imem_req_addr;
            mem_cnt  = mem_lat;
        end
    end

    // Leaves the bench 2 units after the falling edge of the first
    // out-of-reset cycle (C0).
    task automatic do_reset(input int lat, input logic rdy);
        rst_n          = 1'b0;
        stall_fetch    = 1'b0;
        stall_decode   = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        imem_req_ready = 1'b1;
        mem_lat        = lat;
        repeat (3) @(negedge clk);
        rst_n          = 1'b1;
        imem_req_ready = rdy;
        #2;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #2;
        checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid got %0b exp 0", imem_req_valid); end
        checks++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL reset_if_valid got %0b exp 0", if_id_valid); end
        checks++; if (if_id_pc !== 32'h0) begin errors++; $display("FAIL reset_if_pc got %h exp 0", if_id_pc); end
        checks++; if (if_id_inst !== RV_NOP) begin errors++; $display("FAIL reset_if_inst got %h exp %h", if_id_inst, RV_NOP); end
    endtask

    task automatic test_stream_and_stall_decode();
        do_reset(1, 1'b1);
        // C0
        checks++; if ({imem_req_valid, imem_req_addr} !== {1'b1, 32'h100}) begin errors++; $display("FAIL stream_c0_req got %0b/%h exp 1/00000100", imem_req_valid, imem_req_addr); end
        @(negedge clk); #2; // C1
        checks++; if ({imem_req_valid, imem_req_addr} !== {1'b1, 32'h104}) begin errors++; $display("FAIL stream_c1_req got %0b/%h exp 1/00000104", imem_req_valid, imem_req_addr); end
        @(negedge clk); #2; // C2
        checks++; if ({imem_req_valid, imem_req_addr} !== {1'b1, 32'h108}) begin errors++; $display("FAIL stream_c2_req got %0b/%h exp 1/00000108", imem_req_valid, imem_req_addr); end
        checks++; if ({if_id_valid, if_id_pc, if_id_inst} !== {1'b1, 32'h100, 32'hC0DE_0100}) begin errors++; $display("FAIL stream_c2_ifid got %0b/%h/%h exp 1/00000100/c0de0100", if_id_valid, if_id_pc, if_id_inst); end
        // C3..C5: decode stalled with 0x104 in IF/ID, 0x108 parks in buffer
        for (int c = 3; c <= 5; c++) begin
            @(negedge clk);
            stall_decode = 1'b1;
            #2;
            checks++; if ({if_id_valid, if_id_pc, if_id_inst} !== {1'b1, 32'h104, 32'hC0DE_0104}) begin errors++; $display("FAIL stall_hold_c%0d got %0b/%h/%h exp 1/00000104/c0de0104", c, if_id_valid, if_id_pc, if_id_inst); end
            checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL stall_noreq_c%0d got %0b exp 0", c, imem_req_valid); end
        end
        @(negedge clk); // C6: release, buffer drains, still full this cycle
        stall_decode = 1'b0;
        #2;
        checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL drain_noreq got %0b exp 0", imem_req_valid); end
        @(negedge clk); #2; // C7
        checks++; if ({if_id_valid, if_id_pc, if_id_inst} !== {1'b1, 32'h108, 32'hC0DE_0108}) begin errors++; $display("FAIL drain_ifid got %0b/%h/%h exp 1/00000108/c0de0108", if_id_valid, if_id_pc, if_id_inst); end
        checks++; if ({imem_req_valid, imem_req_addr} !== {1'b1, 32'h10C}) begin errors++; $display("FAIL drain_req got %0b/%h exp 1/0000010c", imem_req_valid, imem_req_addr); end
        @(negedge clk); #2; // C8
        checks++; if ({if_id_valid, if_id_inst} !== {1'b0, RV_NOP}) begin errors++; $display("FAIL drain_bubble got %0b/%h exp 0/00000013", if_id_valid, if_id_inst); end
        @(negedge clk); #2; // C9
        checks++; if ({if_id_valid, if_id_pc} !== {1'b1, 32'h10C}) begin errors++; $display("FAIL drain_next got %0b/%h exp 1/0000010c", if_id_valid, if_id_pc); end
    endtask

    task automatic test_redirect();
        bit found = 0;
        do_reset(3, 1'b1);
        if (fire_now && mem_addr == 32'h110) found = 1;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk); #2;
            if (fire_now && mem_addr == 32'h110) found = 1;
        end
        checks++;
        if (!found) begin
            errors++; $display("FAIL redir_wait_0x110 got none exp fire within 40 cycles");
        end else begin
            // F+1: redirect while WAIT, no response this cycle -> DROP
            @(negedge clk);
            redirect_valid = 1'b1; redirect_pc = 32'h2002;
            #2;
            checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL redir_req_withdrawn got %0b exp 0", imem_req_valid); end
            @(negedge clk); // F+2
            redirect_valid = 1'b0;
            #2;
            checks++; if ({if_id_valid, if_id_inst} !== {1'b0, RV_NOP}) begin errors++; $display("FAIL redir_bubble got %0b/%h exp 0/00000013", if_id_valid, if_id_inst); end
            checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL drop_noreq got %0b exp 0", imem_req_valid); end
            @(negedge clk); #2; // F+3: stale response arrives
            checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL drop_stale_noreq got %0b exp 0", imem_req_valid); end
            @(negedge clk); #2; // F+4
            checks++; if ({imem_req_valid, imem_req_addr} !== {1'b1, 32'h2000}) begin errors++; $display("FAIL redir_target_req got %0b/%h exp 1/00002000", imem_req_valid, imem_req_addr); end
            checks++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL stale_dropped got %0b exp 0", if_id_valid); end
            repeat (2) @(negedge clk);
            // F+7: redirect in the same cycle as the response for 0x2000
            @(negedge clk);
            redirect_valid = 1'b1; redirect_pc = 32'h3000;
            #2;
            checks++; if ({imem_rsp_valid, imem_req_valid} !== 2'b10) begin errors++; $display("FAIL redir_rsp_cycle got rsp%0b/req%0b exp rsp1/req0", imem_rsp_valid, imem_req_valid); end
            @(negedge clk); // F+8
            redirect_valid = 1'b0;
            #2;
            checks++; if ({imem_req_valid, imem_req_addr} !== {1'b1, 32'h3000}) begin errors++; $display("FAIL redir_rsp_next_req got %0b/%h exp 1/00003000", imem_req_valid, imem_req_addr); end
            checks++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL redir_rsp_discard got %0b exp 0", if_id_valid); end
        end
    endtask

    task automatic test_stall_fetch();
        do_reset(1, 1'b0);
        checks++; if ({imem_req_valid, imem_req_addr} !== {1'b1, 32'h100}) begin errors++; $display("FAIL sf_c0_req got %0b/%h exp 1/00000100", imem_req_valid, imem_req_addr); end
        for (int c = 1; c <= 2; c++) begin
            @(negedge clk);
            stall_fetch = 1'b1;
            #2;
            checks++; if ({imem_req_valid, imem_req_addr} !== {1'b1, 32'h100}) begin errors++; $display("FAIL sf_hold_c%0d got %0b/%h exp 1/00000100", c, imem_req_valid, imem_req_addr); end
        end
        @(negedge clk); // C3: accepted
        imem_req_ready = 1'b1;
        #2;
        checks++; if (fire_now !== 1'b1) begin errors++; $display("FAIL sf_accept got %0b exp 1", fire_now); end
        @(negedge clk); #2; // C4: response, stalled -> no back-to-back
        checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL sf_no_b2b got %0b exp 0", imem_req_valid); end
        @(negedge clk); #2; // C5
        checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL sf_idle_noreq got %0b exp 0", imem_req_valid); end
        checks++; if ({if_id_valid, if_id_pc} !== {1'b1, 32'h100}) begin errors++; $display("FAIL sf_ifid got %0b/%h exp 1/00000100", if_id_valid, if_id_pc); end
        @(negedge clk); // C6
        stall_fetch = 1'b0;
        #2;
        checks++; if ({imem_req_valid, imem_req_addr} !== {1'b1, 32'h104}) begin errors++; $display("FAIL sf_release_req got %0b/%h exp 1/00000104", imem_req_valid, imem_req_addr); end
    endtask

    task automatic test_reset_mid_wait();
        do_reset(3, 1'b1);
        keep_stale = 1'b1;
        @(negedge clk); // C1: reset while WAIT
        rst_n = 1'b0;
        #2;
        checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL rmw_req_in_reset got %0b exp 0", imem_req_valid); end
        @(negedge clk); // C2
        @(negedge clk); // C3: release, stale response arrives in IDLE
        rst_n = 1'b1;
        #2;
        checks++; if ({imem_req_valid, imem_req_addr} !== {1'b1, 32'h100}) begin errors++; $display("FAIL rmw_first_req got %0b/%h exp 1/00000100", imem_req_valid, imem_req_addr); end
        @(negedge clk); #2; // C4
        checks++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL rmw_stale_ignored got %0b exp 0", if_id_valid); end
        repeat (3) @(negedge clk);
        #2; // C7
        checks++; if ({if_id_valid, if_id_pc} !== {1'b1, 32'h100}) begin errors++; $display("FAIL rmw_real_rsp got %0b/%h exp 1/00000100", if_id_valid, if_id_pc); end
        keep_stale = 1'b0;
    endtask

    // 10 fetches, redirects at C4 and C9 (each with a response in flight),
    // stall_fetch from C14. Bubbles load at the end of C0,C4,C5,C9,C10,C15,C16.
    task automatic test_back_to_back_redirects();
        int obs_bub = 0;
        do_reset(1, 1'b1);
        for (int c = 1; c <= 17; c++) begin
            @(negedge clk);
            redirect_valid = (c == 4) || (c == 9);
            redirect_pc    = (c == 4) ? 32'h2000 : 32'h3001;
            if (c == 14) stall_fetch = 1'b1;
            #2;
            if (!if_id_valid) obs_bub++;
            if (c == 10) begin
                checks++; if ({imem_req_valid, imem_req_addr} !== {1'b1, 32'h3000}) begin errors++; $display("FAIL b2b_redir_align got %0b/%h exp 1/00003000", imem_req_valid, imem_req_addr); end
            end
            if (c == 15) begin
                checks++; if ({if_id_valid, if_id_pc, if_id_inst} !== {1'b1, 32'h300C, 32'hC0DE_300C}) begin errors++; $display("FAIL b2b_last_ifid got %0b/%h/%h exp 1/0000300c/c0de300c", if_id_valid, if_id_pc, if_id_inst); end
            end
        end
        redirect_valid = 1'b0;
        checks++; if (obs_bub !== 7) begin errors++; $display("FAIL b2b_bubble_cycles got %0d exp 7", obs_bub); end
`ifdef RV_FETCH_PERF_EN
        checks++; if (perf_fetch_cnt !== 32'd10) begin errors++; $display("FAIL perf_fetch got %0d exp 10", perf_fetch_cnt); end
        checks++; if (perf_bubble_cnt !== 32'd7) begin errors++; $display("FAIL perf_bubble got %0d exp 7", perf_bubble_cnt); end
`endif
    endtask

    initial begin
        test_reset();
        test_stream_and_stall_decode();
        test_redirect();
        test_stall_fetch();
        test_reset_mid_wait();
        test_back_to_back_redirects();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog");
    end

endmodule
